// File: rtl/stim_player_pkg.sv
// Shared types and default sizing for the stimulus player.
//   state_e        : playback controller states
//   DEF_WIDTH      : default sample width (signed fixed-point)
//   DEF_DEPTH      : default buffer entries (power of 2)
//   DEF_RATE_BITS  : default width of the playback rate divider
package stim_player_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_DEPTH     = 32;
  localparam int unsigned DEF_RATE_BITS = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/stim_player_mem.sv
// Sample storage: one write port, one synchronous read port with read enable.
// The read register only updates on re_i, so it holds the last sample read.
//   clk, rst          : clock, synchronous active-high reset (clears read register)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read request and address
//   rdata_o           : registered read data
module stim_player_mem #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array: contents are not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register doubles as the held output sample.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stim_player.sv
// Stimulus player: loads signed samples into a buffer while idle, then plays
// them out one every rate+1 cycles, optionally looping.
// Loop mode is compiled only when STIM_PLAYER_LOOP_EN is defined; otherwise
// the loop input is ignored and every playback ends after the last entry.
//   clk, rst            : clock, synchronous active-high reset
//   wr_data/wr_valid    : sample load request; wr_ready when buffer can accept
//   start, clear, loop  : playback control; rate = sample period minus one
//   v_out/v_out_valid   : played sample and its one-cycle update strobe
//   busy, done          : playback active; end-of-playback pulse
module stim_player
  import stim_player_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned RATE_BITS = DEF_RATE_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    loop,
  input  logic [RATE_BITS-1:0]    rate,
  output logic signed [WIDTH-1:0] v_out,
  output logic                    v_out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d, count_post;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [RATE_BITS-1:0] div_q, div_d;
  logic [RATE_BITS-1:0] rate_q, rate_d;
  logic                 loop_q, loop_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 wr_ready_q, wr_ready_d;
  logic                 wr_accept, emit, last, loop_eff;
  logic [WIDTH-1:0]     rdata;

`ifdef STIM_PLAYER_LOOP_EN
  assign loop_eff = loop_q;
  assign loop_d   = (state_q == ST_IDLE && !clear && start && count_post != '0) ? loop : loop_q;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_eff    = 1'b0;
  assign loop_d      = 1'b0;
`endif

  // Writes only in IDLE; clear discards a same-cycle write.
  assign wr_accept  = wr_valid && wr_ready_q && (state_q == ST_IDLE) && !clear;
  assign count_post = count_q + CW'(wr_accept);
  assign last       = (rd_ptr_q == AW'(count_q - CW'(1)));
  // Clear in PLAY suppresses the strobe that would otherwise fire this cycle.
  assign emit       = (state_q == ST_PLAY) && (div_q == '0) && !clear;

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    div_d      = div_q;
    rate_d     = rate_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          count_d  = '0;
          wr_ptr_d = '0;
        end else begin
          if (wr_accept) begin
            count_d  = count_post;
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
          if (start && count_post != '0) begin
            state_d  = ST_PLAY;
            rate_d   = rate;
            rd_ptr_d = '0;
            div_d    = '0;
          end
        end
      end
      ST_PLAY: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (emit) begin
          div_d = rate_q;
          if (last) begin
            rd_ptr_d = '0;
            if (!loop_eff) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end else begin
          div_d = div_q - RATE_BITS'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d    = emit;
    // Busy stays high through the final strobe cycle.
    busy_d     = (state_d == ST_PLAY) || emit;
    wr_ready_d = (state_d == ST_IDLE) && (count_d < CW'(DEPTH));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      div_q      <= '0;
      rate_q     <= '0;
      loop_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      div_q      <= div_d;
      rate_q     <= rate_d;
      loop_q     <= loop_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  stim_player_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(AW)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_accept),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .re_i   (emit),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  assign v_out       = $signed(rdata);
  assign v_out_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_ready    = wr_ready_q;

endmodule

// File: tb/tb_stim_player.sv
// Directed bench for stim_player with default parameters.
module tb_stim_player;

  logic               clk;
  logic               rst;
  logic signed [15:0] wr_data;
  logic               wr_valid;
  logic               wr_ready;
  logic               start;
  logic               clear;
  logic               loop;
  logic [7:0]         rate;
  logic signed [15:0] v_out;
  logic               v_out_valid;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  stim_player dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .start      (start),
    .clear      (clear),
    .loop       (loop),
    .rate       (rate),
    .v_out      (v_out),
    .v_out_valid(v_out_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write(input int v);
    wr_valid = 1'b1;
    wr_data  = 16'(v);
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    int s3 [3];
    logic ev;
    s3 = '{100, -200, 300};
    rst = 1'b1; wr_data = '0; wr_valid = 1'b0; start = 1'b0;
    clear = 1'b0; loop = 1'b0; rate = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_vout", v_out, 0);
    chk("rst_valid", v_out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_ready", wr_ready, 1);

    // Three samples at rate 0.
    write(100); write(-200); write(300);
    start = 1'b1; tick(); start = 1'b0;
    chk("r0_entry_busy", busy, 1);
    chk("r0_entry_valid", v_out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r0_valid", v_out_valid, 1);
      chk("r0_vout", v_out, s3[i]);
      chk("r0_done", done, (i == 2) ? 1 : 0);
      chk("r0_busy", busy, 1);
    end
    tick();
    chk("r0_after_valid", v_out_valid, 0);
    chk("r0_after_done", done, 0);
    chk("r0_after_busy", busy, 0);
    chk("r0_hold", v_out, 300);

    // Rate 3; rate input changed mid-play has no effect.
    rate = 8'd3; start = 1'b1; tick(); start = 1'b0; rate = 8'd0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      ev = (c % 4 == 1);
      chk("r3_valid", v_out_valid, ev);
      chk("r3_busy", busy, 1);
      chk("r3_done", done, (c == 9) ? 1 : 0);
      if (ev) chk("r3_vout", v_out, s3[(c - 1) / 4]);
    end
    tick();
    chk("r3_after_busy", busy, 0);

    // Empty buffer: start ignored.
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_wr_ready", wr_ready, 1);
    chk("clr_count", dut.count_q, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_busy", busy, 0);
    tick();
    chk("empty_valid", v_out_valid, 0);
    chk("empty_busy2", busy, 0);

    // Start coinciding with first write.
    wr_valid = 1'b1; wr_data = 16'sd42; start = 1'b1; tick();
    wr_valid = 1'b0; start = 1'b0;
    chk("co_busy", busy, 1);
    tick();
    chk("co_valid", v_out_valid, 1);
    chk("co_vout", v_out, 42);
    chk("co_done", done, 1);
    tick();
    chk("co_after_busy", busy, 0);

    // Fill to DEPTH, then an extra write must be dropped.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 32; i++) begin
      write(i * 10 - 50);
      chk("fill_wr_ready", wr_ready, (i < 31) ? 1 : 0);
    end
    wr_valid = 1'b1; wr_data = 16'sd999; tick(); wr_valid = 1'b0;
    chk("full_count", dut.count_q, 32);
    chk("full_wr_ready", wr_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("full_busy", busy, 1);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("full_valid", v_out_valid, 1);
      chk("full_vout", v_out, i * 10 - 50);
      chk("full_done", done, (i == 31) ? 1 : 0);
    end
    tick();
    chk("full_after_valid", v_out_valid, 0);
    chk("full_after_vout", v_out, 260);

    // Loop with two samples; loop input dropped after start is latched.
    clear = 1'b1; tick(); clear = 1'b0;
    write(5); write(7);
    loop = 1'b1; start = 1'b1; tick(); start = 1'b0; loop = 1'b0;
`ifdef STIM_PLAYER_LOOP_EN
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("loop_valid", v_out_valid, 1);
      chk("loop_vout", v_out, (i % 2 == 1) ? 7 : 5);
      chk("loop_done", done, 0);
      chk("loop_busy", busy, 1);
    end
    clear = 1'b1; tick(); clear = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", v_out_valid, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_valid2", v_out_valid, 0);
    chk("abort_hold", v_out, 7);
    chk("abort_count", dut.count_q, 2);
`else
    tick();
    chk("noloop_vout0", v_out, 5);
    chk("noloop_done0", done, 0);
    tick();
    chk("noloop_vout1", v_out, 7);
    chk("noloop_done1", done, 1);
    tick();
    chk("noloop_busy", busy, 0);
    chk("noloop_valid", v_out_valid, 0);
`endif

    // Reset during playback.
    rate = 8'd3; start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("prerst_valid", v_out_valid, 1);
    chk("prerst_vout", v_out, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_vout", v_out, 0);
    chk("midrst_valid", v_out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wr_ready", wr_ready, 1);
    chk("midrst_count", dut.count_q, 0);
    tick(); tick(); tick(); tick();
    chk("postrst_valid", v_out_valid, 0);
    chk("postrst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stim_player.md
STIM_PLAYER -- requirements
Module: stim_player

Interface
REQ-001 SHALL have parameter WIDTH, default 16, width of signed fixed-point real sample.
REQ-002 SHALL have parameter DEPTH, default 32, sample buffer entries (power of 2).
REQ-003 SHALL have parameter RATE_BITS, default 8, width of playback rate divider.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_data  input  WIDTH  signed sample to load.
REQ-007 SHALL have port wr_valid  input  1  load request.
REQ-008 SHALL have port wr_ready  output  1  buffer can accept a sample.
REQ-009 SHALL have port start  input  1  begin playback pulse.
REQ-010 SHALL have port clear  input  1  empty buffer (IDLE) or abort playback (PLAY).
REQ-011 SHALL have port loop  input  1  repeat buffer continuously.
REQ-012 SHALL have port rate  input  RATE_BITS  sample period minus one, in clk cycles.
REQ-013 SHALL have port v_out  output  WIDTH  signed played sample, registered.
REQ-014 SHALL have port v_out_valid  output  1  one-cycle strobe on each v_out update.
REQ-015 SHALL have port busy  output  1  high while in PLAY.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of non-looped playback.

Function
REQ-017 SHALL implement states IDLE and PLAY only.
REQ-018 SHALL assert wr_ready in IDLE when count < DEPTH, else deassert; write accepted on wr_valid && wr_ready, stored at wr_ptr, count incremented.
REQ-019 SHALL, in IDLE, on start with post-write count > 0, enter PLAY, latch rate and loop, set rd_ptr = 0; start with count == 0 ignored.
REQ-020 SHALL, when start and an accepted write coincide, include the new sample in playback.
REQ-021 SHALL, in PLAY, present sample rd_ptr on v_out with v_out_valid one cycle after entry, then every latched_rate+1 cycles; rate = 0 gives one sample per cycle.
REQ-022 SHALL, after emitting entry count-1: with loop, wrap rd_ptr to 0 and continue the same cadence; without loop, return to IDLE and pulse done in the cycle the last v_out_valid asserts.
REQ-023 SHALL hold v_out at last emitted value between strobes and after playback ends.
REQ-024 SHALL ignore start and writes while in PLAY (wr_ready = 0).
REQ-025 SHALL, on clear in IDLE, set count = 0 and wr_ptr = 0; clear wins over a same-cycle write.
REQ-026 SHALL, on clear in PLAY, return to IDLE next cycle, no done, no further strobe; buffer contents and count retained.
REQ-027 SHALL retain buffer after normal completion so a new start replays it.
REQ-028 SHALL treat rate and loop changes during PLAY as no effect until next start.

Reset
REQ-029 SHALL on rst: state IDLE, count = 0, wr_ptr = 0, rd_ptr = 0, divider = 0, v_out = 0, v_out_valid = 0, done = 0, busy = 0; buffer contents undefined.
REQ-030 SHALL give rst priority over clear, start and writes, including mid-playback.

Configuration
REQ-031 SHALL compile loop mode only when STIM_PLAYER_LOOP_EN is defined; when undefined, loop input ignored and all playback behaves as loop = 0.

Structure
REQ-032 SHALL place state enum and default WIDTH/DEPTH/RATE_BITS constants in package stim_player_pkg.
REQ-033 SHALL place sample storage in sub-module stim_player_mem (one write port, one synchronous read port), with read address prefetched so strobe latency meets REQ-021.

Verification
REQ-034 SHALL verify load 3 samples (100, -200, 300), rate = 0, start -> v_out 100, -200, 300 on consecutive cycles starting 1 cycle after start, done with third strobe.
REQ-035 SHALL verify rate = 3 with same buffer -> strobes exactly 4 cycles apart, busy high from start+1 through last strobe.
REQ-036 SHALL verify DEPTH writes then one more wr_valid -> wr_ready low after 32nd accept, 33rd sample not stored.
REQ-037 SHALL verify loop = 1 (macro defined), 2 samples (5, 7) -> 5, 7, 5, 7, ... no done; clear -> IDLE next cycle, no further strobes.
REQ-038 SHALL verify start with empty buffer -> stays IDLE, no strobe; start with simultaneous first write of 42 -> plays 42, done.
REQ-039 SHALL verify rst asserted mid-PLAY -> next cycle all outputs zero, wr_ready = 1, count = 0.
